// File: rtl/dma_int_event_fifo_if.sv
// Handshake bundle between a DMA channel engine and the interrupt-event queue.
// The master modport belongs to the engine side and the slave modport to the FIFO.
interface dma_int_event_fifo_if #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 5
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                  flush;
    logic                  wrEn;
    logic [FIFO_WIDTH-1:0] wrData;
    logic                  rdEn;
    logic [CNT_W-1:0]      wMark;
    logic                  clrErr;
    logic [FIFO_WIDTH-1:0] rdData;
    logic                  rdValid;
    logic [CNT_W-1:0]      level;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  wMarkFull;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, wrEn, wrData, rdEn, wMark, clrErr,
        input  rdData, rdValid, level, fifoFull, fifoEmpty, wMarkFull, overflow, underflow
    );

    modport slave (
        input  flush, wrEn, wrData, rdEn, wMark, clrErr,
        output rdData, rdValid, level, fifoFull, fifoEmpty, wMarkFull, overflow, underflow
    );
endinterface

// File: rtl/dma_int_event_fifo.sv
// Interrupt-event queue: arbitrary depth, programmable watermark, sticky error flags, flush.
// Define DMA_INT_FIFO_FWFT_EN for a first-word-fall-through read port; default is a registered read.
module dma_int_event_fifo #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 5
) (
    input  logic                clock,
    input  logic                resetn,
    dma_int_event_fifo_if.slave bus
);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_LEVEL = CNT_W'(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]     wr_addr;
    logic [ADDR_W-1:0]     rd_addr;
    logic [CNT_W-1:0]      level_q;
    logic                  full;
    logic                  empty;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  wr_reject;
    logic                  rd_reject;
    logic                  ovf_q;
    logic                  unf_q;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);

    // A pop frees a slot in the same cycle, so a full queue still takes a write alongside it.
    assign rd_accept = bus.rdEn & ~empty & ~bus.flush;
    assign wr_accept = bus.wrEn & (~full | rd_accept) & ~bus.flush;
    assign wr_reject = bus.wrEn & full & ~rd_accept & ~bus.flush;
    assign rd_reject = bus.rdEn & empty & ~bus.flush;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_addr <= '0;
            rd_addr <= '0;
            level_q <= '0;
        end else if (bus.flush) begin
            wr_addr <= '0;
            rd_addr <= '0;
            level_q <= '0;
        end else begin
            if (wr_accept) wr_addr <= next_addr(wr_addr);
            if (rd_accept) rd_addr <= next_addr(rd_addr);
            if (wr_accept && !rd_accept)
                level_q <= level_q + 1'b1;
            else if (rd_accept && !wr_accept)
                level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_accept) mem[wr_addr] <= bus.wrData;
    end

    // A rejection in the same cycle as clrErr wins so no error event is lost.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_reject)       ovf_q <= 1'b1;
            else if (bus.clrErr) ovf_q <= 1'b0;
            if (rd_reject)       unf_q <= 1'b1;
            else if (bus.clrErr) unf_q <= 1'b0;
        end
    end

`ifdef DMA_INT_FIFO_FWFT_EN
    assign bus.rdData  = empty ? '0 : mem[rd_addr];
    assign bus.rdValid = ~empty;
`else
    logic [FIFO_WIDTH-1:0] rd_data_p1;
    logic                  vld_p1;

    // Read stage: head word captured on the accepted pop, held until the next pop.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= rd_accept;
            if (rd_accept) rd_data_p1 <= mem[rd_addr];
        end
    end

    assign bus.rdData  = rd_data_p1;
    assign bus.rdValid = vld_p1;
`endif

    assign bus.level     = level_q;
    assign bus.fifoFull  = full;
    assign bus.fifoEmpty = empty;
    assign bus.wMarkFull = (bus.wMark != '0) && (level_q >= bus.wMark);
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_dma_int_event_fifo.sv
// Self-checking bench for dma_int_event_fifo (DEPTH 5, WIDTH 8) using a queue reference model.
module tb_dma_int_event_fifo;
    localparam int W = 8;
    localparam int D = 5;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] q[$];
    bit           m_ovf, m_unf, m_rdv;
    logic [W-1:0] m_rd;

    dma_int_event_fifo_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) bus();

    dma_int_event_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_unf = 0; m_rdv = 0; m_rd = '0;
    endtask

    task automatic model_step(input bit w, input logic [W-1:0] d, input bit r, input bit f, input bit c);
        bit full, empty, ra, wa;
        full  = (q.size() == D);
        empty = (q.size() == 0);
        if (c) begin m_ovf = 0; m_unf = 0; end
        m_rdv = 0;
        if (f) begin
            q.delete();
        end else begin
            ra = r && !empty;
            wa = w && (!full || ra);
            if (w && !wa) m_ovf = 1;
            if (r && empty) m_unf = 1;
            if (ra) begin m_rd = q.pop_front(); m_rdv = 1; end
            if (wa) q.push_back(d);
        end
    endtask

    task automatic cycle(input bit w, input logic [W-1:0] d, input bit r, input bit f, input bit c);
        bus.wrEn = w; bus.wrData = d; bus.rdEn = r; bus.flush = f; bus.clrErr = c;
        @(posedge clock);
        model_step(w, d, r, f, c);
        #1;
        bus.wrEn = 0; bus.rdEn = 0; bus.flush = 0; bus.clrErr = 0;
    endtask

    task automatic pop(output logic [W-1:0] got, output logic vld);
`ifdef DMA_INT_FIFO_FWFT_EN
        got = bus.rdData; vld = bus.rdValid;
        cycle(0, '0, 1, 0, 0);
`else
        cycle(0, '0, 1, 0, 0);
        got = bus.rdData; vld = bus.rdValid;
`endif
    endtask

    task automatic assert_reset();
        @(negedge clock);
        resetn = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        bus.wrEn = 0; bus.rdEn = 0; bus.flush = 0; bus.clrErr = 0; bus.wrData = '0; bus.wMark = '0;
        assert_reset();
        checks++; if (bus.rdData !== 8'h00) begin errors++; $display("FAIL reset_rdData got %h exp 00", bus.rdData); end
        checks++; if (bus.rdValid !== 1'b0) begin errors++; $display("FAIL reset_rdValid got %b exp 0", bus.rdValid); end
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", bus.level); end
        checks++; if (bus.fifoEmpty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.fifoEmpty); end
        checks++; if (bus.fifoFull !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.fifoFull); end
        checks++; if (bus.wMarkFull !== 1'b0) begin errors++; $display("FAIL reset_wmf got %b exp 0", bus.wMarkFull); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.overflow); end
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_unf got %b exp 0", bus.underflow); end
        release_reset();
    endtask

    task automatic test_basic();
        logic [W-1:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        logic [W-1:0] got;
        logic         vld;
        for (int i = 0; i < 3; i++) cycle(1, exp_d[i], 0, 0, 0);
        checks++; if (bus.level !== 3'd3) begin errors++; $display("FAIL basic_level_fill got %0d exp 3", bus.level); end
        checks++; if (bus.fifoEmpty !== 1'b0) begin errors++; $display("FAIL basic_not_empty got %b exp 0", bus.fifoEmpty); end
        for (int i = 0; i < 3; i++) begin
            pop(got, vld);
            checks++; if (got !== exp_d[i] || vld !== 1'b1) begin errors++; $display("FAIL basic_pop%0d got %h/%b exp %h/1", i, got, vld, exp_d[i]); end
            checks++; if (bus.level !== 3'(2 - i)) begin errors++; $display("FAIL basic_level%0d got %0d exp %0d", i, bus.level, 2 - i); end
        end
        checks++; if (bus.fifoEmpty !== 1'b1) begin errors++; $display("FAIL basic_empty got %b exp 1", bus.fifoEmpty); end
        cycle(0, '0, 0, 0, 0);
        checks++; if (bus.rdValid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got %b exp 0", bus.rdValid); end
`ifndef DMA_INT_FIFO_FWFT_EN
        checks++; if (bus.rdData !== 8'h33) begin errors++; $display("FAIL basic_hold got %h exp 33", bus.rdData); end
`else
        checks++; if (bus.rdData !== 8'h00) begin errors++; $display("FAIL fwft_empty_data got %h exp 00", bus.rdData); end
`endif
    endtask

    task automatic test_overflow();
        logic [W-1:0] got;
        logic         vld;
        for (int i = 0; i < D; i++) cycle(1, 8'hA0 + 8'(i), 0, 0, 0);
        cycle(1, 8'hEE, 0, 0, 0);
        checks++; if (bus.fifoFull !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", bus.fifoFull); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", bus.overflow); end
        checks++; if (bus.level !== 3'd5) begin errors++; $display("FAIL ovf_level got %0d exp 5", bus.level); end
        cycle(1, 8'hEE, 0, 0, 1);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_clr_vs_set got %b exp 1", bus.overflow); end
        for (int i = 0; i < D; i++) begin
            pop(got, vld);
            checks++; if (got !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL ovf_pop%0d got %h exp %h", i, got, 8'hA0 + 8'(i)); end
        end
        checks++; if (bus.fifoEmpty !== 1'b1) begin errors++; $display("FAIL ovf_drained got %b exp 1", bus.fifoEmpty); end
        checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL ovf_no_unf got %b exp 0", bus.underflow); end
        cycle(0, '0, 0, 0, 1);
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", bus.overflow); end
    endtask

    task automatic test_full_rw();
        logic [W-1:0] got;
        logic         vld;
        logic [W-1:0] exp_d;
        for (int i = 0; i < D; i++) cycle(1, 8'hB0 + 8'(i), 0, 0, 0);
        cycle(1, 8'h77, 1, 0, 0);
        checks++; if (bus.level !== 3'd5) begin errors++; $display("FAIL frw_level got %0d exp 5", bus.level); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL frw_ovf got %b exp 0", bus.overflow); end
        checks++; if (bus.fifoFull !== 1'b1) begin errors++; $display("FAIL frw_full got %b exp 1", bus.fifoFull); end
        for (int i = 0; i < D; i++) begin
            exp_d = (i == D - 1) ? 8'h77 : 8'hB1 + 8'(i);
            pop(got, vld);
            checks++; if (got !== exp_d) begin errors++; $display("FAIL frw_pop%0d got %h exp %h", i, got, exp_d); end
        end
    endtask

    task automatic test_underflow_wrap();
        logic [W-1:0] got;
        logic         vld;
        logic         exp_v;
        cycle(0, '0, 1, 0, 0);
        checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL unf_flag got %b exp 1", bus.underflow); end
        checks++; if (bus.rdValid !== 1'b0) begin errors++; $display("FAIL unf_valid got %b exp 0", bus.rdValid); end
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL unf_level got %0d exp 0", bus.level); end
        cycle(0, '0, 0, 0, 1);
        cycle(1, 8'h5A, 1, 0, 0);
`ifdef DMA_INT_FIFO_FWFT_EN
        exp_v = 1'b1;
`else
        exp_v = 1'b0;
`endif
        checks++; if (bus.underflow !== 1'b1 || bus.level !== 3'd1 || bus.rdValid !== exp_v) begin
            errors++; $display("FAIL unf_wr_rd got unf=%b lvl=%0d vld=%b exp 1/1/%b", bus.underflow, bus.level, bus.rdValid, exp_v);
        end
        pop(got, vld);
        checks++; if (got !== 8'h5A) begin errors++; $display("FAIL unf_wr_rd_data got %h exp 5a", got); end
        cycle(0, '0, 0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            cycle(1, 8'hC0 + 8'(i), 0, 0, 0);
            pop(got, vld);
            checks++; if (got !== 8'hC0 + 8'(i) || vld !== 1'b1) begin errors++; $display("FAIL wrap%0d got %h/%b exp %h/1", i, got, vld, 8'hC0 + 8'(i)); end
        end
    endtask

    task automatic test_watermark_flush();
        logic [W-1:0] got;
        logic         vld;
        bus.wMark = 3'd3;
        cycle(0, '0, 1, 0, 0);
        cycle(1, 8'hD0, 0, 0, 0);
        cycle(1, 8'hD1, 0, 0, 0);
        checks++; if (bus.wMarkFull !== 1'b0) begin errors++; $display("FAIL wm_lvl2 got %b exp 0", bus.wMarkFull); end
        cycle(1, 8'hD2, 0, 0, 0);
        checks++; if (bus.wMarkFull !== 1'b1) begin errors++; $display("FAIL wm_lvl3 got %b exp 1", bus.wMarkFull); end
        cycle(1, 8'hD3, 0, 0, 0);
        checks++; if (bus.wMarkFull !== 1'b1) begin errors++; $display("FAIL wm_lvl4 got %b exp 1", bus.wMarkFull); end
        bus.wMark = 3'd0; #1;
        checks++; if (bus.wMarkFull !== 1'b0) begin errors++; $display("FAIL wm_zero got %b exp 0", bus.wMarkFull); end
        bus.wMark = 3'd6; #1;
        checks++; if (bus.wMarkFull !== 1'b0) begin errors++; $display("FAIL wm_above_depth got %b exp 0", bus.wMarkFull); end
        bus.wMark = 3'd3;
        cycle(1, 8'hEF, 1, 1, 0);
        checks++; if (bus.level !== 3'd0 || bus.fifoEmpty !== 1'b1) begin errors++; $display("FAIL flush_level got %0d/%b exp 0/1", bus.level, bus.fifoEmpty); end
        checks++; if (bus.rdValid !== 1'b0 || bus.wMarkFull !== 1'b0) begin errors++; $display("FAIL flush_valid got %b/%b exp 0/0", bus.rdValid, bus.wMarkFull); end
        checks++; if (bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin errors++; $display("FAIL flush_flags got unf=%b ovf=%b exp 1/0", bus.underflow, bus.overflow); end
        cycle(1, 8'hD9, 0, 0, 1);
        pop(got, vld);
        checks++; if (got !== 8'hD9) begin errors++; $display("FAIL flush_reuse got %h exp d9", got); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < D + 1; i++) cycle(1, 8'h30 + 8'(i), 0, 0, 0);
        cycle(0, '0, 1, 0, 0);
        @(negedge clock); #2;
        resetn = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.level !== 3'd0 || bus.fifoEmpty !== 1'b1 || bus.fifoFull !== 1'b0) begin
            errors++; $display("FAIL midrst_level got %0d/%b/%b exp 0/1/0", bus.level, bus.fifoEmpty, bus.fifoFull);
        end
        checks++; if (bus.overflow !== 1'b0 || bus.rdValid !== 1'b0 || bus.rdData !== 8'h00) begin
            errors++; $display("FAIL midrst_out got ovf=%b vld=%b data=%h exp 0/0/00", bus.overflow, bus.rdValid, bus.rdData);
        end
        release_reset();
    endtask

    task automatic test_random();
        bit           w, r, f, c;
        int           bias;
        logic [W-1:0] exp_rd;
        logic         exp_v, exp_wmf;
        assert_reset();
        release_reset();
        for (int n = 0; n < 800; n++) begin
            if (n % 40 == 0) bias = $urandom_range(20, 80);
            w = ($urandom_range(99) < bias);
            r = ($urandom_range(99) >= bias);
            f = ($urandom_range(63) == 0);
            c = ($urandom_range(15) == 0);
            bus.wMark = 3'($urandom_range(6));
            cycle(w, 8'($urandom), r, f, c);
`ifdef DMA_INT_FIFO_FWFT_EN
            exp_v  = (q.size() != 0);
            exp_rd = exp_v ? q[0] : '0;
`else
            exp_v  = m_rdv;
            exp_rd = m_rd;
`endif
            exp_wmf = (bus.wMark != 0) && (q.size() >= int'(bus.wMark));
            checks++; if (bus.level !== 3'(q.size())) begin errors++; $display("FAIL rnd_level@%0d got %0d exp %0d", n, bus.level, q.size()); end
            checks++; if (bus.fifoFull !== (q.size() == D)) begin errors++; $display("FAIL rnd_full@%0d got %b", n, bus.fifoFull); end
            checks++; if (bus.fifoEmpty !== (q.size() == 0)) begin errors++; $display("FAIL rnd_empty@%0d got %b", n, bus.fifoEmpty); end
            checks++; if (bus.wMarkFull !== exp_wmf) begin errors++; $display("FAIL rnd_wmf@%0d got %b exp %b", n, bus.wMarkFull, exp_wmf); end
            checks++; if (bus.overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf@%0d got %b exp %b", n, bus.overflow, m_ovf); end
            checks++; if (bus.underflow !== m_unf) begin errors++; $display("FAIL rnd_unf@%0d got %b exp %b", n, bus.underflow, m_unf); end
            checks++; if (bus.rdValid !== exp_v) begin errors++; $display("FAIL rnd_valid@%0d got %b exp %b", n, bus.rdValid, exp_v); end
            checks++; if (bus.rdData !== exp_rd) begin errors++; $display("FAIL rnd_data@%0d got %h exp %h", n, bus.rdData, exp_rd); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_rw();
        test_underflow_wrap();
        test_watermark_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
